rk_step_update: RTL

//  Final-stage solution update of the RK step. Consumes the registered Butcher

---
 rtl/rk_pkg.sv | 33 +++
 rtl/rk_mac.sv | 35 +++
 rtl/rk_step_update.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rk_pkg.sv
// Shared types and helpers for the RK final-stage update: FSM state encoding,
// fixed-point defaults and a generic signed saturator.
package rk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        SCALE = 2'd2,
        OUT   = 2'd3
    } rk_state_e;

    localparam int RK_FRAC = 16;

    // Container width for saturation; callers sign-extend their sums into it.
    localparam int SAT_W = 128;

    function automatic logic signed [SAT_W-1:0] sat(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) << (w - 32'd1)) - SAT_W'(1);
        lo = ~hi;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/rk_mac.sv
// Single signed WIDTH x WIDTH multiplier feeding a wide accumulator.
// clr has priority over en; the accumulator is wide enough never to wrap.
module rk_mac #(
    parameter int WIDTH = 32,
    parameter int ACC_W = 66
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;

    assign a_ext    = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext    = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + prod_ext;
    end

endmodule

// File: rtl/rk_step_update.sv
// Final RK solution update: y1 = y0 + h0*sum(b[j]*k[j]), x1 = x0 + h0,
// using one shared MAC stepped over the stages, with saturated outputs.
//
// state | meaning
// IDLE  | waiting for i_start; snapshots operands on launch
// ACC   | one b[j]*k[j] accumulate per cycle, S cycles
// SCALE | t = ((acc >>> FRAC) * h0) >>> FRAC registered
// OUT   | saturated x1/y1 registered, o_done pulsed
module rk_step_update
    import rk_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int S     = 3,
    parameter int FRAC  = RK_FRAC
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic signed [WIDTH-1:0] i_b [S-1:0],
    input  logic signed [WIDTH-1:0] i_k [S-1:0],
    input  logic signed [WIDTH-1:0] i_x0,
    input  logic signed [WIDTH-1:0] i_y0,
    input  logic signed [WIDTH-1:0] i_h0,
    output logic                    o_busy,
    output logic                    o_done,
    output logic signed [WIDTH-1:0] o_x1,
    output logic signed [WIDTH-1:0] o_y1,
    output logic                    o_sat
);

    localparam int ACC_W  = 2*WIDTH + $clog2(S+1);
    localparam int PROD_W = ACC_W - FRAC + WIDTH;
    localparam int SUM_W  = PROD_W + 1;
    localparam int IDX_W  = (S > 1) ? $clog2(S) : 1;

    rk_state_e state_q, state_d;
    logic      load, mac_en, scale_en, out_en;

    logic signed [WIDTH-1:0]  b_q [S-1:0];
    logic signed [WIDTH-1:0]  k_q [S-1:0];
    logic signed [WIDTH-1:0]  x0_q, y0_q, h0_q;
    logic        [IDX_W-1:0]  j_q;
    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] t_q;

    rk_mac #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (i_rst),
        .clr (load),
        .en  (mac_en),
        .a   (b_q[j_q]),
        .b   (k_q[j_q]),
        .acc (acc)
    );

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        mac_en   = 1'b0;
        scale_en = 1'b0;
        out_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    load    = 1'b1;
                    state_d = ACC;
                end
            end
            ACC: begin
                mac_en = 1'b1;
                if (j_q == IDX_W'(S-1))
                    state_d = SCALE;
            end
            SCALE: begin
                scale_en = 1'b1;
                state_d  = OUT;
            end
            OUT: begin
                out_en  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy = (state_q != IDLE);

    // Scaling datapath: every intermediate kept at full width, floor shifts.
    logic signed [ACC_W-1:0]  acc_shr;
    logic signed [PROD_W-1:0] acc_shr_ext;
    logic signed [PROD_W-1:0] h0_ext;
    logic signed [PROD_W-1:0] scale_prod;

    assign acc_shr     = acc >>> FRAC;
    assign acc_shr_ext = {{(PROD_W-ACC_W){acc_shr[ACC_W-1]}}, acc_shr};
    assign h0_ext      = {{(PROD_W-WIDTH){h0_q[WIDTH-1]}}, h0_q};
    assign scale_prod  = acc_shr_ext * h0_ext;

    logic signed [SUM_W-1:0] y_sum;
    logic signed [WIDTH:0]   x_sum;
    logic signed [SAT_W-1:0] y_wide, y_clamp;
    logic signed [SAT_W-1:0] x_wide, x_clamp;
    logic                    y_sat, x_sat;

    assign y_sum   = {{(SUM_W-WIDTH){y0_q[WIDTH-1]}}, y0_q} + {t_q[PROD_W-1], t_q};
    assign x_sum   = {x0_q[WIDTH-1], x0_q} + {h0_q[WIDTH-1], h0_q};
    assign y_wide  = {{(SAT_W-SUM_W){y_sum[SUM_W-1]}}, y_sum};
    assign x_wide  = {{(SAT_W-WIDTH-1){x_sum[WIDTH]}}, x_sum};
    assign y_clamp = sat(y_wide, WIDTH);
    assign x_clamp = sat(x_wide, WIDTH);
    assign y_sat   = (y_clamp != y_wide);
    assign x_sat   = (x_clamp != x_wide);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < S; i++) begin
                b_q[i] <= '0;
                k_q[i] <= '0;
            end
            x0_q   <= '0;
            y0_q   <= '0;
            h0_q   <= '0;
            j_q    <= '0;
            t_q    <= '0;
            o_x1   <= '0;
            o_y1   <= '0;
            o_sat  <= 1'b0;
            o_done <= 1'b0;
        end else begin
            if (load) begin
                b_q  <= i_b;
                k_q  <= i_k;
                x0_q <= i_x0;
                y0_q <= i_y0;
                h0_q <= i_h0;
                j_q  <= '0;
            end else if (mac_en) begin
                j_q <= j_q + IDX_W'(1);
            end
            if (scale_en)
                t_q <= scale_prod >>> FRAC;
            if (out_en) begin
                o_x1  <= x_clamp[WIDTH-1:0];
                o_y1  <= y_clamp[WIDTH-1:0];
                o_sat <= x_sat | y_sat;
            end
            o_done <= out_en;
        end
    end

endmodule
